// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// SEQ_DIVIDER_SIGNED_EN adds the FIXUP state used for signed operation.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
`ifdef SEQ_DIVIDER_SIGNED_EN
    , FIXUP = 2'd3
`endif
  } state_t;

  // Fill bit replicated across quotient/remainder on a zero divisor.
  localparam logic DIV_ZERO_Q = 1'b1;
  localparam logic DIV_ZERO_R = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// The WIDTH+1-bit trial value lives here, so the held remainder needs only WIDTH bits.
module seq_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_next_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_a,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {i_a, i_next_bit};
  assign w_diff  = w_trial - {1'b0, i_divisor};
  assign o_q_bit = (w_trial >= {1'b0, i_divisor});
  // The kept value is always below the divisor, so it fits back into WIDTH bits.
  assign o_a     = WIDTH'(o_q_bit ? w_diff : w_trial);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for the is_signed port and two's-complement mode.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_a_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quot_next;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_sgn_op;
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_dvd;
  logic w_neg_dvs;

  assign w_neg_dvd = is_signed & dividend[WIDTH-1];
  assign w_neg_dvs = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_neg_dvd ? -dividend : dividend;
  assign w_dvs_mag = w_neg_dvs ? -divisor : divisor;
  assign w_finish  = w_last && !r_sgn_op;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_finish  = w_last;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_div_zero  = (divisor == '0);
  assign w_last      = (r_cnt == CNT_W'(1));
  assign w_quot_next = {r_work[WIDTH-2:0], w_q_bit};

  // The working register shifts dividend bits out of its top as quotient bits enter below.
  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_a       (r_a),
    .i_next_bit(r_work[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_a       (w_a_next),
    .o_q_bit   (w_q_bit)
  );

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) w_state_next = w_div_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (w_last) w_state_next = r_sgn_op ? FIXUP : DONE;
`else
        if (w_last) w_state_next = DONE;
`endif
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIXUP: w_state_next = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && rst_n;
        if (out_ready) begin
          if (in_valid) w_state_next = w_div_zero ? DONE : RUN;
          else          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_work  <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_sgn_op <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (w_div_zero) begin
          r_quot <= {WIDTH{DIV_ZERO_Q}};
          r_rem  <= {WIDTH{DIV_ZERO_R}};
          r_dbz  <= 1'b1;
        end else begin
          r_a    <= '0;
          r_work <= w_dvd_mag;
          r_dvs  <= w_dvs_mag;
          r_cnt  <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
          r_sgn_op <= is_signed;
          r_neg_q  <= w_neg_dvd ^ w_neg_dvs;
          r_neg_r  <= w_neg_dvd;
`endif
        end
      end else if (r_state == RUN) begin
        r_a    <= w_a_next;
        r_work <= w_quot_next;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (w_finish) begin
          r_quot <= w_quot_next;
          r_rem  <= w_a_next;
          r_dbz  <= 1'b0;
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      else if (r_state == FIXUP) begin
        // Magnitudes are done; apply truncate-toward-zero signs.
        r_quot <= r_neg_q ? -r_work : r_work;
        r_rem  <= r_neg_r ? -r_a : r_a;
        r_dbz  <= 1'b0;
      end
`endif
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider. It is the clocked successor of the team's combinational 8-bit unsigned divider.
- Resolves one quotient bit per clock.
- valid/ready handshakes on the operand and result sides.
- Result is held until consumed.
- Sits between the pin-level operand registers and the output muxing in the TinyTapeout wrapper, and is reusable wherever a small divider is needed.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- dividend  input  WIDTH  numerator, sampled on in_valid && in_ready.
- divisor  input  WIDTH  denominator, sampled on in_valid && in_ready.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes the result.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  result came from a zero divisor.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, out_valid=0. in_ready goes high the cycle after rst_n deasserts.
- Reset mid-operation discards the operation with no result emitted. Reset always has priority.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept with divisor!=0: latch operands, clear partial remainder A (WIDTH+1 bits), counter=WIDTH, go to RUN.
  - On accept with divisor==0: go directly to DONE with quotient={WIDTH{1}}, remainder={WIDTH{1}}, div_by_zero=1.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: A={A[WIDTH-1:0], next dividend MSB}. If A>=divisor, then A=A-divisor and shift 1 into quotient; else shift 0. counter decrements.
  - When counter reaches 1, the final step completes and the state goes to DONE.
- DONE:
  - out_valid=1.
  - quotient, remainder and div_by_zero are held stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_ready=1 only in the cycle where out_ready=1 (back-to-back): a simultaneous in_valid accepts new operands and goes straight to RUN, or to DONE if divisor==0.
- Latency, nonzero divisor: accept at edge N, out_valid high from edge N+WIDTH+1. Throughput is one result per WIDTH+1 cycles with out_ready tied high.
- Latency, zero divisor: out_valid high at edge N+1.
- Arithmetic:
  - A is WIDTH+1 bits, so no overflow is possible.
  - Results satisfy dividend == quotient*divisor + remainder, with remainder < divisor.
  - dividend < divisor gives quotient=0, remainder=dividend.
- Operand inputs are ignored outside the accept cycle. Changing them during RUN has no effect.
- quotient and remainder change only on the transition into DONE.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled with the operands.
  - When is_signed=1, operands are two's complement. The block divides the magnitudes and then fixes the signs in one extra cycle, so latency is WIDTH+2.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 gives quotient=-2^(WIDTH-1) and remainder=0, with no flag.
  - Divide-by-zero behaves as in unsigned mode.
- Undefined: no is_signed port, unsigned only, latency WIDTH+1.

Decomposition:
- Package seq_divider_pkg: state enum (IDLE, RUN, DONE, plus FIXUP when signed), DIV_ZERO_Q/DIV_ZERO_R fill constants.
- Sub-module div_step: combinational one-iteration shift/compare/subtract.
  - Inputs: A, next bit, divisor.
  - Outputs: new A, quotient bit.
  - Reused by the unrolled combinational divider variant.

Test Plan:
- WIDTH=8, 100/7, out_ready=1 -> out_valid exactly 9 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
- 200/0 -> out_valid 1 cycle after accept, quotient=0xFF, remainder=0xFF, div_by_zero=1.
- 5/9, then 255/1 -> quotient=0 and remainder=5; then quotient=255 and remainder=0.
- out_ready low 20 cycles after 77/5 -> outputs held at q=15 r=2; in_ready=0 throughout; release -> IDLE.
- Back-to-back: out_ready=1 with in_valid in the DONE cycle -> new op accepted that cycle; randomised 10k ops checked against a reference model for WIDTH=8 and WIDTH=16.
- rst_n low mid-RUN -> next cycle out_valid=0 and quotient=0; a following 9/3 gives q=3 r=0. With SEQ_DIVIDER_SIGNED_EN: -7/2 signed -> q=-3 r=-1; -128/-1 -> q=-128 r=0.
